// File: rtl/freq_monitor_pkg.sv
// Shared types and helpers for the time-shared clock frequency monitor.
// Estimator instantiation sites use freq_width so both sides agree on the estimate width.
package freq_monitor_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PICK,
    S_SETTLE,
    S_SAMPLE
  } state_t;

  function automatic int freq_width(input int period, input int factor);
    return $clog2(period * factor);
  endfunction

endpackage

// File: rtl/freq_monitor_rr_pick.sv
// Round-robin next-set-bit finder: first set mask bit strictly after last_idx, wrapping.
// none is raised when the mask is empty; next_idx is then meaningless.
module freq_monitor_rr_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  mask,
  input  logic [SW-1:0] last_idx,
  output logic [SW-1:0] next_idx,
  output logic          none
);

  logic [N-1:0] scan;
  logic         found;
  int           offset;

  // Rotate the mask so bit 0 is the channel right after last_idx, then find the first one.
  always_comb begin
    scan   = N'({mask, mask} >> (int'(last_idx) + 1));
    found  = 1'b0;
    offset = 0;
    for (int i = 0; i < N; i++) begin
      if (!found && scan[0]) begin
        offset = i;
        found  = 1'b1;
      end
      scan = scan >> 1;
    end
    next_idx = SW'((int'(last_idx) + 1 + offset) % N);
    none     = ~found;
  end

endmodule

// File: rtl/freq_monitor_scheduler.sv
// Time-shares one frequency estimator across CHANNELS clocks: steer mux, wait out a
// contaminated window, sample the estimate, check limits and publish the result.
module freq_monitor_scheduler
  import freq_monitor_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int PERIOD   = 1000,
  parameter  int FACTOR   = 2,
  localparam int FW       = freq_width(PERIOD, FACTOR),
  localparam int SW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [CHANNELS-1:0]          chan_mask,
  input  logic [CHANNELS-1:0][FW-1:0]  lim_lo,
  input  logic [CHANNELS-1:0][FW-1:0]  lim_hi,
  input  logic                         clear,
  output logic [SW-1:0]                freq_sel,
  input  logic [FW-1:0]                frequency,
  output logic                         res_valid,
  output logic [SW-1:0]                res_chan,
  output logic [FW-1:0]                res_freq,
  output logic                         res_fault,
  output logic [CHANNELS-1:0]          fault,
  output logic                         busy
);

  // One possibly straddled window, one full window, plus the estimator's 4-cycle pipeline.
  localparam int            SETTLE      = 2 * PERIOD + 4;
  localparam int            CW          = $clog2(SETTLE);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);

  state_t               state;
  state_t               state_nxt;
  logic [CW-1:0]        settle_cnt;
  logic [SW-1:0]        last_chan;
  logic [SW-1:0]        pick_chan;
  logic                 pick_none;
  logic                 out_of_range;
  logic [CHANNELS-1:0]  fault_set;

  freq_monitor_rr_pick #(
    .N  (CHANNELS),
    .SW (SW)
  ) u_pick (
    .mask     (chan_mask),
    .last_idx (last_chan),
    .next_idx (pick_chan),
    .none     (pick_none)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (enable && (chan_mask != '0)) state_nxt = S_PICK;
      S_PICK:   state_nxt = (!enable || pick_none) ? S_IDLE : S_SETTLE;
      S_SETTLE: begin
        if (!enable)                 state_nxt = S_IDLE;
        else if (settle_cnt == '0)   state_nxt = S_SAMPLE;
      end
      S_SAMPLE: state_nxt = enable ? S_PICK : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_of_range = (frequency < lim_lo[freq_sel]) || (frequency > lim_hi[freq_sel]);
    fault_set    = '0;
    if ((state == S_SAMPLE) && out_of_range) fault_set = CHANNELS'(1) << freq_sel;
  end

  // last_chan resets to the top channel so the very first search lands on channel 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_sel   <= '0;
      last_chan  <= SW'(CHANNELS - 1);
      settle_cnt <= '0;
      res_valid  <= 1'b0;
      res_chan   <= '0;
      res_freq   <= '0;
      res_fault  <= 1'b0;
      fault      <= '0;
    end else begin
      res_valid <= 1'b0;
      if ((state == S_PICK) && enable && !pick_none) begin
        freq_sel   <= pick_chan;
        last_chan  <= pick_chan;
        settle_cnt <= SETTLE_LOAD;
      end
      if ((state == S_SETTLE) && (settle_cnt != '0)) settle_cnt <= settle_cnt - CW'(1);
      if (state == S_SAMPLE) begin
        res_valid <= 1'b1;
        res_chan  <= freq_sel;
        res_freq  <= frequency;
        res_fault <= out_of_range;
      end
      fault <= (clear ? '0 : fault) | fault_set;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_freq_monitor_scheduler.sv
// Scoreboard bench for freq_monitor_scheduler: stimulus pushes expected results,
// a negedge monitor pops and compares them whenever res_valid is seen.
module tb_freq_monitor_scheduler;

  localparam int CYCLE = 2 * 100 + 4 + 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             clear;
  logic [3:0]       chan_mask;
  logic [3:0][8:0]  lim_lo;
  logic [3:0][8:0]  lim_hi;
  logic [8:0]       frequency;
  logic [1:0]       freq_sel;
  logic             res_valid;
  logic [1:0]       res_chan;
  logic [8:0]       res_freq;
  logic             res_fault;
  logic [3:0]       fault;
  logic             busy;

  typedef struct {
    logic [1:0] chan;
    logic [8:0] freq;
    logic       flt;
    logic [3:0] fvec;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_err = 0;
  logic [1:0] m_last;
  logic [3:0] m_fault;

  freq_monitor_scheduler #(
    .CHANNELS (4),
    .PERIOD   (100),
    .FACTOR   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .chan_mask (chan_mask),
    .lim_lo    (lim_lo),
    .lim_hi    (lim_hi),
    .clear     (clear),
    .freq_sel  (freq_sel),
    .frequency (frequency),
    .res_valid (res_valid),
    .res_chan  (res_chan),
    .res_freq  (res_freq),
    .res_fault (res_fault),
    .fault     (fault),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_next(input logic [1:0] last, input logic [3:0] mask);
    logic [1:0] c;
    c = last;
    for (int k = 0; k < 4; k++) begin
      c = c + 2'd1;
      if (mask[c]) return c;
    end
    return last;
  endfunction

  function automatic logic [8:0] rand9();
    return 9'($urandom_range(0, 511));
  endfunction

  // Monitor: every result strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (res_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_result: got res_valid on chan %0d, expected none", res_chan);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("res_chan",  int'(res_chan),  int'(mon_e.chan));
        checkOutput("res_freq",  int'(res_freq),  int'(mon_e.freq));
        checkOutput("res_fault", int'(res_fault), int'(mon_e.flt));
        checkOutput("fault_vec", int'(fault),     int'(mon_e.fvec));
      end
    end
  end

  task automatic checkResetValues();
    checkOutput("rst_freq_sel",  int'(freq_sel),  0);
    checkOutput("rst_res_valid", int'(res_valid), 0);
    checkOutput("rst_res_chan",  int'(res_chan),  0);
    checkOutput("rst_res_freq",  int'(res_freq),  0);
    checkOutput("rst_res_fault", int'(res_fault), 0);
    checkOutput("rst_fault",     int'(fault),     0);
    checkOutput("rst_busy",      int'(busy),      0);
  endtask

  // One measurement: predict channel/result, then follow it to its res_valid strobe.
  task automatic applyStimulus(input logic [8:0] f, input bit from_idle, input bit clr_at_sample,
                               input bit clr_mid, input bit mask_mid_zero);
    exp_t       e;
    int         cyc;
    int         lat;
    int         sel_cyc;
    logic [1:0] c;
    c         = model_next(m_last, chan_mask);
    m_last    = c;
    frequency = f;
    if (clr_mid) m_fault = '0;
    e.chan = c;
    e.freq = f;
    e.flt  = (f < lim_lo[c]) || (f > lim_hi[c]);
    if (clr_at_sample) m_fault = '0;
    if (e.flt) m_fault[c] = 1'b1;
    e.fvec = m_fault;
    sb.push_back(e);
    lat     = from_idle ? CYCLE + 1 : CYCLE;
    sel_cyc = from_idle ? 2 : 1;
    cyc     = 0;
    do begin
      @(negedge clk);
      cyc++;
      clear = (clr_at_sample && (cyc == lat - 1)) || (clr_mid && (cyc == 50));
      if (cyc == sel_cyc) checkOutput("freq_sel", int'(freq_sel), int'(c));
      if (clr_mid && (cyc == 51)) checkOutput("clear_alone", int'(fault), 0);
      if (mask_mid_zero && (cyc == 60)) chan_mask = 4'b0000;
    end while (!res_valid && (cyc < 2 * CYCLE));
    clear = 1'b0;
    checkOutput("latency", cyc, lat);
  endtask

  initial begin
    logic [1:0] c;
    reset     = 1'b1;
    enable    = 1'b0;
    clear     = 1'b0;
    chan_mask = 4'b0000;
    frequency = '0;
    lim_lo    = '0;
    lim_hi    = {4{9'd511}};
    repeat (3) @(negedge clk);
    checkResetValues();
    reset   = 1'b0;
    m_last  = 2'd3;
    m_fault = '0;
    @(negedge clk);
    checkOutput("idle_busy", int'(busy), 0);

    // Basic rotation over all four channels.
    $display("[TB] basic rotation");
    chan_mask = 4'b1111;
    enable    = 1'b1;
    applyStimulus(9'd200, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (4) applyStimulus(9'd200, 1'b0, 1'b0, 1'b0, 1'b0);

    // Masked channels, then mask dropped mid-settle.
    $display("[TB] masked channels");
    chan_mask = 4'b1010;
    repeat (3) applyStimulus(9'd200, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(9'd200, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mask0_idle", int'(busy), 0);
    repeat (300) @(negedge clk);
    checkOutput("mask0_still_idle", int'(busy), 0);

    // Limit boundaries on a single channel.
    $display("[TB] limit checks");
    lim_lo[2] = 9'd150;
    lim_hi[2] = 9'd250;
    chan_mask = 4'b0100;
    applyStimulus(9'd149, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(9'd150, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(9'd250, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(9'd251, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clear colliding with a failing sample, then clear alone.
    $display("[TB] clear priority");
    applyStimulus(9'd300, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(9'd200, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort during settle.
    $display("[TB] abort");
    chan_mask = 4'b1111;
    c         = model_next(m_last, chan_mask);
    m_last    = c;
    repeat (51) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle", int'(busy), 0);
    checkOutput("abort_sel_hold", int'(freq_sel), int'(c));
    lim_hi[0] = 9'd300;
    repeat (300) @(negedge clk);
    enable = 1'b1;
    applyStimulus(9'd400, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a settle on channel 1.
    $display("[TB] reset mid-run");
    lim_hi[0] = 9'd511;
    repeat (100) @(negedge clk);
    checkOutput("pre_reset_sel", int'(freq_sel), int'(model_next(m_last, chan_mask)));
    reset = 1'b1;
    @(negedge clk);
    checkResetValues();
    reset   = 1'b0;
    m_last  = 2'd3;
    m_fault = '0;
    applyStimulus(9'd77, 1'b1, 1'b0, 1'b0, 1'b0);

    // Randomized masks, limits (including inverted ranges), frequencies and clears.
    $display("[TB] random passes");
    for (int n = 0; n < 20; n++) begin
      chan_mask = 4'($urandom_range(1, 15));
      lim_lo    = {rand9(), rand9(), rand9(), rand9()};
      lim_hi    = {rand9(), rand9(), rand9(), rand9()};
      applyStimulus(rand9(), 1'b0, ($urandom_range(0, 4) == 0), 1'b0, 1'b0);
    end

    enable = 1'b0;
    repeat (2 * CYCLE) @(negedge clk);
    checkOutput("sb_drain", sb.size(), 0);
    checkOutput("final_idle", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/freq_monitor_scheduler.md
# freq_monitor_scheduler

Time-shares one clock frequency estimator across several monitored clocks. Steers an external clock mux, waits until a full uncontaminated measurement window has been counted, captures the estimate, checks it against per-channel limits and publishes the result. Runs in the estimator's reference clock domain and advances round-robin over enabled channels.

## Interface
- CHANNELS, 4, number of monitored clocks (1..64)
- PERIOD, 1000, estimator window in clk cycles; must match the estimator instance
- FACTOR, 2, maximum estclk/refclk ratio; must match the estimator instance
- FW (localparam) = $clog2(FACTOR*PERIOD), estimate width
- SW (localparam) = max(1, $clog2(CHANNELS)), channel index width
- SETTLE (localparam) = 2*PERIOD + 4, post-switch wait in cycles

Ports:
- clk  in  1  reference clock; the same clock as the estimator's refclk
- reset  in  1  synchronous, active-high
- enable  in  1  run scheduling while high
- chan_mask  in  CHANNELS  1 = channel participates
- lim_lo  in  CHANNELS×FW  per-channel lower limit, inclusive
- lim_hi  in  CHANNELS×FW  per-channel upper limit, inclusive
- clear  in  1  clears all sticky fault flags
- freq_sel  out  SW  select for the external clock mux
- frequency  in  FW  estimator output
- res_valid  out  1  one-cycle result strobe
- res_chan  out  SW  channel of the current result
- res_freq  out  FW  captured estimate
- res_fault  out  1  result lies outside [lim_lo, lim_hi]
- fault  out  CHANNELS  sticky per-channel out-of-range flags
- busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, PICK, SETTLE, SAMPLE.
- **IDLE:** go to PICK when enable=1 and chan_mask≠0.
- **PICK:** one cycle.
  - Select the next set chan_mask bit strictly after the last measured channel, wrapping. After reset the search starts at channel 0.
  - Register it into freq_sel.
  - Load the settle counter with SETTLE−1.
  - Go to SETTLE.
  - If mask=0, return to IDLE.
- **SETTLE:** decrement the counter. Go to SAMPLE when it reaches 0.
- **SAMPLE:** one cycle.
  - Capture frequency into res_freq and freq_sel into res_chan.
  - Compute out = (frequency < lim_lo[ch]) | (frequency > lim_hi[ch]). Comparisons are unsigned, FW bits.
  - Pulse res_valid and drive res_fault=out.
  - If out, set fault[ch].
  - Next state is PICK if enable=1, else IDLE.
- **clear:** clears fault in the same cycle edge. Simultaneous clear and set on the same bit: the set wins.
- **enable deasserted in PICK or SETTLE:** abort to IDLE the next cycle. No result is produced and freq_sel holds.
- **Mask:** sampled only in PICK. A mask change during SETTLE does not abort the current measurement.
- **Single enabled channel:** re-measured continuously, with freq_sel unchanged.
- **lim_lo > lim_hi:** every result faults. This is not prevented.

## Timing
- Reset values:
  - state = IDLE
  - freq_sel = 0, last channel = CHANNELS−1, so the first pick starts at 0
  - res_valid = 0, res_chan = 0, res_freq = 0, res_fault = 0
  - fault = 0, busy = 0
- Reset mid-operation returns to the reset values on the next edge, regardless of state.
- **freq_sel update:** changes on the clock edge leaving PICK.
- **Settle time:** exactly SETTLE cycles in SETTLE, then the res_valid pulse at the end of SAMPLE.
  - Measurement latency from the freq_sel change to res_valid high is SETTLE+1 cycles.
  - Rationale: the first estimator window after a switch may straddle it. The next full window completes within 2*PERIOD cycles, plus 4 cycles of estimator pipeline (2 sync stages, strobe, output register).
- **Outputs:** res_chan, res_freq and res_fault are registered and hold until the next SAMPLE. fault updates on the same edge as res_valid.
- **Cycle per channel:** SETTLE+2 cycles (PICK + SETTLE + SAMPLE), back to back while enabled.
- **Counters:** the settle counter is $clog2(SETTLE) bits wide and never wraps.

## Structure
- Package freq_monitor_pkg holds:
  - the state enum type (IDLE, PICK, SETTLE, SAMPLE)
  - a function computing FW from PERIOD and FACTOR, shared with estimator instantiation sites
- Sub-module freq_monitor_rr_pick: combinational round-robin next-set-bit finder. Inputs are mask and last index; outputs are next index and a none flag. It is reusable and tested in isolation.
- The estimator itself and the clock mux live outside this block. Their wiring is done at the parent level.

## Test plan
Parameters for all scenarios: CHANNELS=4, PERIOD=100, FACTOR=4 (FW=9, SETTLE=204). The bench models the estimator with a driven frequency value.

1. **Basic rotation.** Reset, then enable=1, mask=4'b1111, all limits [0,511], frequency=200.
   - freq_sel steps 0,1,2,3,0.
   - res_valid occurs every 206 cycles and the first arrives 206 cycles after PICK.
   - res_freq=200, fault=0.
2. **Masked channels.** mask=4'b1010.
   - Only channels 1 and 3 are measured, alternating.
   - Set mask=0 mid-SETTLE: the current result still completes, then the FSM goes to IDLE and busy=0.
3. **Limit checks.** Channel 2 limits [150,250]. Drive frequency 149, 150, 250, 251 on successive passes.
   - res_fault = 1, 0, 0, 1 respectively.
   - fault[2] is set on the first fail and remains set.
4. **Clear priority.** Assert clear in the same cycle as a failing SAMPLE on channel 2: fault[2]=1. Assert clear alone later: fault=0.
5. **Abort.** Deassert enable 50 cycles into SETTLE.
   - No res_valid is produced.
   - The FSM is in IDLE the next cycle, freq_sel holds.
   - Re-enable: the next pick is the following channel.
6. **Reset mid-run.** Assert reset mid-SETTLE on channel 1.
   - All outputs return to reset values.
   - After release with enable high, the first measurement is on channel 0.
